// File: rtl/arm_pipe_pkg.sv
// Shared definitions for the ARM-subset pipeline stages.
package arm_pipe_pkg;

    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] NOP_INSTR = 32'h0;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load, flush to a bubble, or hold. Flush wins over load.
module if_id_reg
    import arm_pipe_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              flush,
    input  logic [WORD_W-1:0] next_pc,
    input  logic [WORD_W-1:0] next_instr,
    output logic [WORD_W-1:0] pc_out,
    output logic [WORD_W-1:0] instruction,
    output logic              valid
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_out      <= '0;
            instruction <= NOP_INSTR;
            valid       <= 1'b0;
        end else if (flush) begin
            pc_out      <= '0;
            instruction <= NOP_INSTR;
            valid       <= 1'b0;
        end else if (load) begin
            pc_out      <= next_pc;
            instruction <= next_instr;
            valid       <= 1'b1;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, req/ready fetch port, one-entry skid buffer for
// decode freezes, and branch redirect with draining of an outstanding request.
module if_stage
    import arm_pipe_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [WORD_W-1:0] PC_INC   = 32'd4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              branch_taken,
    input  logic [WORD_W-1:0] branch_addr,
    output logic              imem_req,
    output logic [WORD_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [WORD_W-1:0] imem_rdata,
    output logic [WORD_W-1:0] pc_out,
    output logic [WORD_W-1:0] instruction,
    output logic              valid
);

    fetch_state_t      state, state_d;
    logic [WORD_W-1:0] pc, pc_d, pc_inc;
    logic [WORD_W-1:0] target, target_d;
    logic [WORD_W-1:0] buf_pc, buf_pc_d, buf_instr, buf_instr_d;
    logic              load, flush;
    logic [WORD_W-1:0] next_pc, next_instr;

    assign pc_inc    = pc + PC_INC;
    assign imem_addr = pc;
    // Request is gated by reset so a late ready during reset cannot transfer.
    assign imem_req  = rst && (state != HOLD);

    always_comb begin
        state_d     = state;
        pc_d        = pc;
        target_d    = target;
        buf_pc_d    = buf_pc;
        buf_instr_d = buf_instr;
        load        = 1'b0;
        flush       = 1'b0;
        next_pc     = pc_inc;
        next_instr  = imem_rdata;
        case (state)
            FETCH: begin
                if (branch_taken) begin
                    flush = 1'b1;
                    if (imem_ready) begin
                        pc_d = branch_addr;
                    end else begin
                        // Address must stay stable until the pending request completes.
                        target_d = branch_addr;
                        state_d  = DRAIN;
                    end
                end else if (imem_ready) begin
                    pc_d = pc_inc;
                    if (freeze) begin
                        buf_pc_d    = pc_inc;
                        buf_instr_d = imem_rdata;
                        state_d     = HOLD;
                    end else begin
                        load = 1'b1;
                    end
                end else if (!freeze) begin
                    flush = 1'b1;
                end
            end
            HOLD: begin
                if (branch_taken) begin
                    pc_d    = branch_addr;
                    flush   = 1'b1;
                    state_d = FETCH;
                end else if (!freeze) begin
                    load       = 1'b1;
                    next_pc    = buf_pc;
                    next_instr = buf_instr;
                    state_d    = FETCH;
                end
            end
            DRAIN: begin
                flush = 1'b1;
                if (imem_ready) begin
                    pc_d    = branch_taken ? branch_addr : target;
                    state_d = FETCH;
                end else if (branch_taken) begin
                    target_d = branch_addr;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            target    <= '0;
            buf_pc    <= '0;
            buf_instr <= '0;
        end else begin
            state     <= state_d;
            pc        <= pc_d;
            target    <= target_d;
            buf_pc    <= buf_pc_d;
            buf_instr <= buf_instr_d;
        end
    end

    if_id_reg u_if_id (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .flush       (flush),
        .next_pc     (next_pc),
        .next_instr  (next_instr),
        .pc_out      (pc_out),
        .instruction (instruction),
        .valid       (valid)
    );

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios plus a randomized run, with a queue of
// expected program-order fetch addresses consumed by an independent monitor.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] pc_out;
    logic [31:0] instruction;
    logic        valid;

    always #5 clk = ~clk;

    if_stage #(.RESET_PC(32'h0000_0000), .PC_INC(32'd4)) dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .pc_out       (pc_out),
        .instruction  (instruction),
        .valid        (valid)
    );

    // Instruction memory contents: a scrambled function of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'h1357_9BDF;
    endfunction

    always_comb imem_rdata = mem_word(imem_addr);

    int checks   = 0;
    int errors   = 0;
    int consumed = 0;

    // Expected stream seen by decode: sequential words from the latest restart point.
    logic [31:0] exp_q[$];
    logic [31:0] q_tail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b expected=%b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic topup();
        while (exp_q.size() < 32) begin
            q_tail = q_tail + 32'd4;
            exp_q.push_back(q_tail);
        end
    endtask

    task automatic restart_q(input logic [31:0] a);
        exp_q.delete();
        q_tail = a;
        exp_q.push_back(a);
        topup();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        topup();
    endtask

    // Monitor: decode takes the IF/ID word on an edge where valid, no freeze, no flush.
    logic        pend = 1'b0;
    logic [31:0] pend_addr = '0;
    logic [31:0] mon_a;

    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            pend <= 1'b0;
        end else begin
            if (pend) begin
                check1("req_stable", imem_req, 1'b1);
                check("addr_stable", imem_addr, pend_addr);
            end
            if (!valid) begin
                check("bubble_instr", instruction, 32'h0);
                check("bubble_pc", pc_out, 32'h0);
            end else if (!freeze && !branch_taken) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL stream_empty actual=%h expected=none", pc_out);
                end else begin
                    mon_a = exp_q.pop_front();
                    check("stream_instr", instruction, mem_word(mon_a));
                    check("stream_pc", pc_out, mon_a + 32'd4);
                    consumed++;
                end
            end
            pend      <= imem_req && !imem_ready;
            pend_addr <= imem_addr;
        end
    end

    logic [31:0] r, t;

    initial begin
        rst = 1'b0; freeze = 1'b0; branch_taken = 1'b0; branch_addr = '0; imem_ready = 1'b1;
        q_tail = '0;
        repeat (3) @(negedge clk);
        check1("rst_valid", valid, 1'b0);
        check("rst_instr", instruction, 32'h0);
        check("rst_pc_out", pc_out, 32'h0);
        check1("rst_req", imem_req, 1'b0);
        check("rst_addr", imem_addr, 32'h0);
        #1 rst = 1'b1;
        restart_q(32'h0);
        #1;
        check1("first_req", imem_req, 1'b1);
        check("first_addr", imem_addr, 32'h0);

        // Zero-wait fetch, then freeze for three edges while word 8 returns.
        tick();
        @(negedge clk);
        check1("e1_valid", valid, 1'b1);
        check("e1_instr", instruction, mem_word(32'h0));
        check("e1_pc", pc_out, 32'h4);
        check("e1_addr", imem_addr, 32'h4);
        tick();
        freeze = 1'b1;
        @(negedge clk);
        check("e2_addr", imem_addr, 32'h8);
        check("e2_pc", pc_out, 32'h8);
        tick();
        @(negedge clk);
        check1("hold_req", imem_req, 1'b0);
        check("hold_pc", pc_out, 32'h8);
        check("hold_instr", instruction, mem_word(32'h4));
        tick();
        tick();
        freeze = 1'b0;
        @(negedge clk);
        check("hold_pc2", pc_out, 32'h8);
        tick();
        imem_ready = 1'b0;
        @(negedge clk);
        check("rel_pc", pc_out, 32'hC);
        check("rel_instr", instruction, mem_word(32'h8));
        check("rel_addr", imem_addr, 32'hC);
        check1("rel_req", imem_req, 1'b1);

        // One-cycle wait states.
        tick();
        imem_ready = 1'b1;
        @(negedge clk);
        check1("ws_valid0", valid, 1'b0);
        check("ws_addr", imem_addr, 32'hC);
        tick();
        imem_ready = 1'b0;
        @(negedge clk);
        check1("ws_valid1", valid, 1'b1);
        check("ws_instr", instruction, mem_word(32'hC));

        // Branch while the request at 0x10 is still unaccepted.
        tick();
        branch_taken = 1'b1; branch_addr = 32'h100; restart_q(32'h100);
        @(negedge clk);
        check1("ws_valid2", valid, 1'b0);
        check("br_addr_pre", imem_addr, 32'h10);
        tick();
        branch_taken = 1'b0;
        @(negedge clk);
        check("drain_addr", imem_addr, 32'h10);
        check1("drain_req", imem_req, 1'b1);
        check1("drain_valid", valid, 1'b0);
        tick();
        imem_ready = 1'b1;
        @(negedge clk);
        check("drain_addr2", imem_addr, 32'h10);
        tick();
        @(negedge clk);
        check("redir_addr", imem_addr, 32'h100);
        check1("redir_valid", valid, 1'b0);
        tick();
        freeze = 1'b1;
        @(negedge clk);
        check1("br_valid", valid, 1'b1);
        check("br_instr", instruction, mem_word(32'h100));

        // Branch while held in HOLD with freeze still asserted.
        tick();
        branch_taken = 1'b1; branch_addr = 32'h200; restart_q(32'h200);
        @(negedge clk);
        check1("hb_req", imem_req, 1'b0);
        tick();
        branch_taken = 1'b0; freeze = 1'b0;
        @(negedge clk);
        check1("hb_valid", valid, 1'b0);
        check("hb_addr", imem_addr, 32'h200);
        tick();
        branch_taken = 1'b1; branch_addr = 32'hFFFF_FFFC; restart_q(32'hFFFF_FFFC);
        @(negedge clk);
        check("hb_pc", pc_out, 32'h204);

        // PC wrap.
        tick();
        branch_taken = 1'b0;
        @(negedge clk);
        check("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        tick();
        imem_ready = 1'b0; branch_taken = 1'b1; branch_addr = 32'h40; restart_q(32'h40);
        @(negedge clk);
        check("wrap_pc", pc_out, 32'h0);
        check1("wrap_valid", valid, 1'b1);
        check("wrap_addr", imem_addr, 32'h0);

        // Asynchronous reset in the middle of DRAIN, then a late ready.
        tick();
        branch_taken = 1'b0;
        #2 rst = 1'b0;
        #1;
        check1("mid_valid", valid, 1'b0);
        check("mid_instr", instruction, 32'h0);
        check("mid_pc", pc_out, 32'h0);
        check1("mid_req", imem_req, 1'b0);
        check("mid_addr", imem_addr, 32'h0);
        imem_ready = 1'b1;
        @(posedge clk);
        #1;
        check("late_addr", imem_addr, 32'h0);
        check1("late_valid", valid, 1'b0);
        @(negedge clk);
        #1 rst = 1'b1;
        restart_q(32'h0);

        // Randomized traffic.
        for (int c = 0; c < 1500; c++) begin
            tick();
            imem_ready = ($urandom % 10) < 7;
            freeze     = ($urandom % 10) < 3;
            if (($urandom % 16) == 0) begin
                r = $urandom;
                case ($urandom % 4)
                    0:       t = 32'hFFFF_FFF8;
                    1:       t = 32'h100;
                    default: t = {r[31:2], 2'b00};
                endcase
                branch_taken = 1'b1;
                branch_addr  = t;
                restart_q(t);
            end else begin
                branch_taken = 1'b0;
            end
            if (c == 700) begin
                branch_taken = 1'b0;
                #2 rst = 1'b0;
                @(negedge clk);
                #1 rst = 1'b1;
                restart_q(32'h0);
            end
        end
        tick();
        branch_taken = 1'b0; freeze = 1'b0;
        @(negedge clk);
        check1("liveness", consumed > 200, 1'b1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
